issue_unit: RTL and testbench

- Upstream feeder for the ALU: fetches 16-bit instructions over a simple request/acknowledge memory port and decodes them.
- Holds the 8x16 general register file, drives the ALU operands, opcode and enable, and writes the ALU result back.
- Two-operand machine: rd <= rd op src, where src is register rs or a 16-bit immediate carried in the following word.
- ALU flags are consumed only as a one-cycle-late status export.

---
 rtl/issue_unit.sv | 181 ++++++++++++++++++
 tb/tb_issue_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : issue_unit
// Brief    : Fetches and decodes two-operand instructions (rd <= rd op src),
//            owns the general register file and drives the ALU.
//            Optional macro ISSUE_SINGLE_STEP_EN adds step_i and a HOLD state.
// Revision : 1.0 - initial release
// ============================================================================
module issue_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          NREGS    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef ISSUE_SINGLE_STEP_EN
    input  logic        step_i,
`endif
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [3:0]  op_o,
    output logic [15:0] data1_o,
    output logic [15:0] data2_o,
    output logic        alu_en_o,
    input  logic [15:0] alu_data_i,
    input  logic        zf_i,
    input  logic        sf_i,
    input  logic        cf_i,
    input  logic        of_i,
    output logic [15:0] pc_o,
    output logic        busy_o
);

    // ALU encoding of compare: result is discarded, only flags matter
    localparam logic [3:0] c_OP_CMP = 4'h6;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMM   = 3'd1,
        S_READ  = 3'd2,
`ifdef ISSUE_SINGLE_STEP_EN
        S_HOLD  = 3'd4,
`endif
        S_EXEC  = 3'd3
    } state_t;

`ifdef ISSUE_SINGLE_STEP_EN
    localparam state_t c_IDLE_STATE = S_HOLD;
`else
    localparam state_t c_IDLE_STATE = S_FETCH;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_imm;
    logic [15:0] r_d1;
    logic [15:0] r_d2;
    logic [3:0]  r_op;
    logic [10:0] r_ir;      // instruction bits [15:5]; [4:0] carry no meaning
    logic [15:0] r_regs [NREGS];

    logic        w_req;
    logic        w_alu_en;
    logic        w_busy;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic        w_has_imm;
    logic        w_unused;

    assign w_rd      = r_ir[6:4];
    assign w_rs      = r_ir[3:1];
    assign w_has_imm = r_ir[0];

    // Flags are produced for the outside world one cycle late; nothing here reacts to them
    assign w_unused  = ^{zf_i, sf_i, cf_i, of_i, imem_data_i[4:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_IDLE_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_alu_en = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_busy = 1'b0;
                if (imem_ack_i) begin
                    w_next = imem_data_i[5] ? S_IMM : S_READ;
                end
            end
            S_IMM: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_alu_en = 1'b1;
                w_next   = c_IDLE_STATE;
            end
`ifdef ISSUE_SINGLE_STEP_EN
            S_HOLD: begin
                w_busy = 1'b0;
                if (step_i) begin
                    w_next = S_FETCH;
                end
            end
`endif
            default: begin
                w_next = c_IDLE_STATE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_imm <= '0;
            r_op  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        r_ir <= imem_data_i[15:5];
                        r_pc <= r_pc + 16'd1;
                    end
                end
                S_IMM: begin
                    if (imem_ack_i) begin
                        r_imm <= imem_data_i;
                        r_pc  <= r_pc + 16'd1;
                    end
                end
                S_READ: begin
                    r_op <= r_ir[10:7];
                    r_d1 <= r_regs[w_rd];
                    r_d2 <= w_has_imm ? r_imm : r_regs[w_rs];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_EXEC && r_op != c_OP_CMP) begin
            r_regs[w_rd] <= alu_data_i;
        end
    end

    // Reset gates the request directly so an outstanding fetch is withdrawn at once
    assign imem_req_o  = w_req & ~rst_i;
    assign imem_addr_o = r_pc;
    assign alu_en_o    = w_alu_en;
    assign op_o        = r_op;
    assign data1_o     = r_d1;
    assign data2_o     = r_d2;
    assign pc_o        = r_pc;
    assign busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_unit
// Brief    : Randomized scoreboard bench for issue_unit with an in-bench ALU,
//            memory responder and instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_unit;

    localparam logic [15:0] RESET_PC = 16'hFFFE;
    localparam logic [3:0]  OP_MOV   = 4'd0;
    localparam logic [3:0]  OP_ADD   = 4'd1;
    localparam logic [3:0]  OP_XOR   = 4'd5;
    localparam logic [3:0]  OP_CMP   = 4'd6;
`ifdef ISSUE_SINGLE_STEP_EN
    localparam int HOLD_CYC = 1;
`else
    localparam int HOLD_CYC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
`ifdef ISSUE_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic [3:0]  op;
    logic [15:0] data1, data2, alu_data, pc;
    logic        alu_en, busy;
    logic        zf = 1'b0, sf = 1'b0, cf = 1'b0, of = 1'b0;

    always #5 clk = ~clk;

    issue_unit #(.RESET_PC(RESET_PC), .NREGS(8)) dut (
        .clk_i(clk), .rst_i(rst),
`ifdef ISSUE_SINGLE_STEP_EN
        .step_i(step),
`endif
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_data_i(imem_data),
        .op_o(op), .data1_o(data1), .data2_o(data2), .alu_en_o(alu_en),
        .alu_data_i(alu_data),
        .zf_i(zf), .sf_i(sf), .cf_i(cf), .of_i(of),
        .pc_o(pc), .busy_o(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] m_regs [8];
    logic [15:0] m_pc;
    int          m_cyc;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          exec_cnt = 0;
    int          fixed_wait = 0;
    int          max_wait = 0;
    bit          spurious = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    int          cur_wait = 0;
    logic [15:0] hold_addr = 16'h0;
    bit          got_first = 1'b0;
    logic [15:0] first_addr = 16'h0;

    function automatic logic [15:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd0:       return b;
            4'd1:       return a + b;
            4'd2, 4'd6: return a - b;
            4'd3:       return a & b;
            4'd4:       return a | b;
            4'd5:       return a ^ b;
            default:    return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    // Bench-side ALU: combinational result, flags registered on the enable edge
    assign alu_data = alu_f(op, data1, data2);
    always @(posedge clk) begin
        if (alu_en) begin
            zf <= (alu_data == 16'h0);
            sf <= alu_data[15];
            cf <= ({1'b0, data1} + {1'b0, data2}) > 17'h0FFFF;
            of <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc  = RESET_PC;
        m_cyc = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        sb.delete();
        mem.delete();
    endtask

    // One instruction at the spec level: rd <= rd op src, CMP writes nothing
    task automatic emit(input logic [3:0] o, input logic [2:0] rd, input logic [2:0] rs,
                        input bit im, input logic [15:0] iv, input bit timed);
        exp_t        e;
        logic [15:0] src;
        mem[m_pc] = {o, rd, rs, im, 5'($urandom)};
        m_pc = m_pc + 16'd1;
        if (im) begin
            mem[m_pc] = iv;
            m_pc = m_pc + 16'd1;
        end
        src   = im ? iv : m_regs[rs];
        m_cyc = m_cyc + HOLD_CYC + (im ? 4 : 3);
        e.op  = o;
        e.d1  = m_regs[rd];
        e.d2  = src;
        e.pc  = m_pc;
        e.cyc = timed ? m_cyc : -1;
        if (o != OP_CMP) m_regs[rd] = alu_f(o, m_regs[rd], src);
        sb.push_back(e);
    endtask

    task automatic emit_random(input int n, input bit timed);
        for (int i = 0; i < n; i++) begin
            emit(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 16'($urandom), timed);
        end
    endtask

    task automatic emit_dump(input bit timed);
        for (int r = 0; r < 8; r++) emit(OP_CMP, 3'(r), 3'd0, 1'b1, 16'h0, timed);
    endtask

    task automatic check_reset();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_op", op, 4'h0);
        chk("rst_data1", data1, 16'h0);
        chk("rst_data2", data2, 16'h0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_busy", busy, 1'b0);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_remaining", sb.size(), 0);
    endtask

    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc++;
    end

    // Memory responder: acks only words that belong to the loaded program
    always @(negedge clk) begin
        if (rst) begin
            imem_ack  = 1'b0;
            pending   = 1'b0;
            got_first = 1'b0;
        end else if (imem_req) begin
            if (!got_first) begin
                got_first  = 1'b1;
                first_addr = imem_addr;
            end
            if (pending) begin
                chk("addr_stable", imem_addr, hold_addr);
            end else begin
                pending   = 1'b1;
                cnt       = 0;
                hold_addr = imem_addr;
                cur_wait  = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, max_wait);
            end
            if (cnt >= cur_wait && mem.exists(imem_addr)) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                pending   = 1'b0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 16'($urandom);
                cnt++;
            end
        end else begin
            imem_ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_data = 16'($urandom);
            pending   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && alu_en) begin
            exec_cnt++;
            chk("busy_in_exec", busy, 1'b1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_exec actual=op %h data1 %h required=no instruction pending", op, data1);
            end else begin
                mon_e = sb.pop_front();
                chk("exec_op", op, mon_e.op);
                chk("exec_data1", data1, mon_e.d1);
                chk("exec_data2", data2, mon_e.d2);
                chk("exec_pc", pc, mon_e.pc);
                if (mon_e.cyc >= 0) chk("exec_cycle", cyc + 1, mon_e.cyc);
            end
        end
    end

    initial begin
        bit          found;
        logic [15:0] imm_addr;
        imm_addr = RESET_PC + 16'd1;

        // Phase A: zero-wait memory, exact cycle timing, PC wrap through FFFF
        model_reset();
        emit(OP_XOR, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1);
        emit(OP_MOV, 3'd1, 3'd0, 1'b1, 16'h1234, 1'b1);
        emit(OP_MOV, 3'd2, 3'd0, 1'b1, 16'hFFFF, 1'b1);
        emit(OP_MOV, 3'd3, 3'd0, 1'b1, 16'h0001, 1'b1);
        emit(OP_ADD, 3'd2, 3'd3, 1'b0, 16'h0, 1'b1);
        emit(OP_MOV, 3'd4, 3'd0, 1'b1, 16'h0005, 1'b1);
        emit(OP_CMP, 3'd4, 3'd0, 1'b1, 16'h0005, 1'b1);
        emit(OP_ADD, 3'd4, 3'd4, 1'b0, 16'h0, 1'b1);
        emit(OP_CMP, 3'd2, 3'd2, 1'b0, 16'h0, 1'b1);
        emit_random(50, 1'b1);
        emit_dump(1'b1);
        repeat (3) @(posedge clk);
        #1 check_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_drain(3000);
        chk("first_req_addr_a", first_addr, RESET_PC);

        // Phase B: reset aborts an outstanding immediate fetch
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_reset();
        model_reset();
        emit(OP_MOV, 3'd5, 3'd0, 1'b1, 16'hBEEF, 1'b0);
        emit_random(50, 1'b0);
        emit_dump(1'b0);
        fixed_wait = 3;
        @(posedge clk);
        #1 rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == imm_addr) found = 1'b1;
        end
        chk("imm_req_seen", found, 1'b1);
        #1 rst = 1'b1;
        #1 chk("req_async_drop", imem_req, 1'b0);
        repeat (2) @(posedge clk);

        // Phase B run: random wait states, spurious acks while not fetching
        fixed_wait = -1;
        max_wait   = 3;
        spurious   = 1'b1;
`ifdef ISSUE_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #1 rst = 1'b0;
`ifdef ISSUE_SINGLE_STEP_EN
        begin
            int reqs;
            int base;
            int n;
            reqs = 0;
            repeat (10) begin
                @(negedge clk);
                if (imem_req) reqs++;
            end
            chk("hold_no_req", reqs, 0);
            base = exec_cnt;
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            n = 0;
            while (exec_cnt == base && n < 100) begin
                @(negedge clk);
                n++;
            end
            reqs = 0;
            repeat (10) begin
                @(negedge clk);
                if (imem_req) reqs++;
            end
            chk("step_no_req_after", reqs, 0);
            chk("step_exec_count", exec_cnt - base, 1);
            step = 1'b1;
        end
`endif
        wait_drain(6000);
        chk("first_req_addr_b", first_addr, RESET_PC);
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
